// File: rtl/imm_encode.sv
// rtl/imm_encode.sv - RISC-V immediate packer with registered output; optional IMM_ERR_COUNT_EN error counter
module imm_encode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm_val,
    input  logic [2:0]  imm_src,
    input  logic [31:0] base_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        range_err,
    output logic        src_err
`ifdef IMM_ERR_COUNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    logic [31:0] clr_mask;
    logic [31:0] field;
    logic [31:0] enc_instr;
    logic        enc_range;
    logic        enc_src;
    logic        accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        clr_mask  = 32'h0000_0000;
        field     = 32'h0000_0000;
        enc_range = 1'b0;
        enc_src   = 1'b0;
        case (imm_src)
            SRC_I: begin
                clr_mask  = 32'hFFF0_0000;
                field     = {imm_val[11:0], 20'h0};
                enc_range = imm_val != {{20{imm_val[11]}}, imm_val[11:0]};
            end
            SRC_S: begin
                clr_mask  = 32'hFE00_0F80;
                field     = {imm_val[11:5], 13'h0, imm_val[4:0], 7'h0};
                enc_range = imm_val != {{20{imm_val[11]}}, imm_val[11:0]};
            end
            SRC_B: begin
                clr_mask  = 32'hFE00_0F80;
                field     = {imm_val[12], imm_val[10:5], 13'h0, imm_val[4:1], imm_val[11], 7'h0};
                enc_range = (imm_val != {{19{imm_val[12]}}, imm_val[12:0]}) || imm_val[0];
            end
            SRC_J: begin
                clr_mask  = 32'hFFFF_F000;
                field     = {imm_val[20], imm_val[10:1], imm_val[11], imm_val[19:12], 12'h0};
                enc_range = (imm_val != {{11{imm_val[20]}}, imm_val[20:0]}) || imm_val[0];
            end
            SRC_U: begin
                clr_mask  = 32'hFFFF_F000;
                field     = {imm_val[31:12], 12'h0};
                enc_range = imm_val[11:0] != 12'h0;
            end
            default: begin
                enc_src = 1'b1;
            end
        endcase
        enc_instr = (base_instr & ~clr_mask) | field;
    end

    // Output register: loads on accept, otherwise drops valid once the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            instr     <= 32'h0;
            range_err <= 1'b0;
            src_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            instr     <= enc_instr;
            range_err <= enc_range;
            src_err   <= enc_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef IMM_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 16'h0;
        end else if (accept && (enc_range || enc_src) && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_encode.sv
// tb/tb_imm_encode.sv - scoreboard bench for imm_encode
module tb_imm_encode;

    typedef struct packed {
        logic [31:0] instr;
        logic        r;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm_val;
    logic [2:0]  imm_src;
    logic [31:0] base_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        range_err;
    logic        src_err;
`ifdef IMM_ERR_COUNT_EN
    logic [15:0] err_count;
    logic [15:0] err_model;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t cur_exp;
    logic rst_q;
    logic acc_prev  = 1'b0;
    logic hold_prev = 1'b0;
    logic [31:0] prev_instr;
    logic rand_done;

    imm_encode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_val(imm_val), .imm_src(imm_src), .base_instr(base_instr),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .range_err(range_err), .src_err(src_err)
`ifdef IMM_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference packing built field-by-field from the format tables.
    function automatic exp_t model(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] base);
        exp_t e;
        int signed v;
        v = $signed(imm);
        e.s = 1'b0;
        case (src)
            3'd0: begin e.instr = {imm[11:0], base[19:0]}; e.r = (v < -2048) || (v > 2047); end
            3'd1: begin e.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]}; e.r = (v < -2048) || (v > 2047); end
            3'd2: begin
                e.instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                e.r = (v < -4096) || (v > 4095) || imm[0];
            end
            3'd3: begin
                e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                e.r = (v < -1048576) || (v > 1048575) || imm[0];
            end
            3'd4: begin e.instr = {imm[31:12], base[11:0]}; e.r = imm[11:0] != 12'h0; end
            default: begin e.instr = base; e.r = 1'b0; e.s = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic send(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] base, input exp_t e);
        int waited;
        in_valid   = 1'b1;
        imm_val    = imm;
        imm_src    = src;
        base_instr = base;
        cur_exp    = e;
        waited     = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] base);
        send(imm, src, base, model(imm, src, base));
    endtask

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        exp_t e;
        if (rst_q === 1'b1) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_errs", {30'd0, range_err, src_err}, 32'd0);
        end else begin
            if (acc_prev) check("latency", 32'(out_valid), 32'd1);
            if (hold_prev) check("stable", instr, prev_instr);
        end
        check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
`ifdef IMM_ERR_COUNT_EN
        check("err_count", 32'(err_count), 32'(err_model));
`endif
        acc_prev  = 1'b0;
        hold_prev = 1'b0;
        if (rst) begin
            q.delete();
`ifdef IMM_ERR_COUNT_EN
            err_model = 16'h0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                check("xfer_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("instr", instr, e.instr);
                    check("range_err", 32'(range_err), 32'(e.r));
                    check("src_err", 32'(src_err), 32'(e.s));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(cur_exp);
                acc_prev = 1'b1;
`ifdef IMM_ERR_COUNT_EN
                if ((cur_exp.r || cur_exp.s) && err_model != 16'hFFFF) err_model = err_model + 16'h1;
`endif
            end
            if (out_valid && !out_ready) begin
                hold_prev  = 1'b1;
                prev_instr = instr;
            end
        end
    end

    initial begin
        int waited;
        rst        = 1'b1;
        in_valid   = 1'b0;
        imm_val    = 32'h0;
        imm_src    = 3'd0;
        base_instr = 32'h0;
        out_ready  = 1'b1;
        cur_exp    = '0;
`ifdef IMM_ERR_COUNT_EN
        err_model  = 16'h0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(32'hFFFFF800, 3'b000, 32'h00002003, '{32'h80002003, 1'b0, 1'b0});
        send(32'h00000010, 3'b001, 32'h00002023, '{32'h00002823, 1'b0, 1'b0});
        send(32'h12345000, 3'b100, 32'h00000037, '{32'h12345037, 1'b0, 1'b0});
        send(32'h00000008, 3'b010, 32'h00000063, '{32'h00000463, 1'b0, 1'b0});
        send(32'h00000009, 3'b010, 32'h00000063, '{32'h00000463, 1'b1, 1'b0});
        send(32'h00100000, 3'b011, 32'h0000006F, '{32'h8000006F, 1'b1, 1'b0});
        send(32'h00100000, 3'b110, 32'hDEADBEEF, '{32'hDEADBEEF, 1'b0, 1'b1});
        send(32'hFFF00000, 3'b011, 32'h000000EF, '{32'h800000EF, 1'b0, 1'b0});
        send(32'h00000800, 3'b000, 32'h00000013, '{32'h80000013, 1'b1, 1'b0});
        send(32'h00000ABC, 3'b100, 32'h00000017, '{32'h00000017, 1'b1, 1'b0});
        @(posedge clk);

        // Backpressure: second request must wait for out_ready.
        #1 out_ready = 1'b0;
        send_m(32'h000007FF, 3'b000, 32'h00000093);
        fork
            send_m(32'hFFFFF000, 3'b001, 32'h00001023);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                check("bp_release_ready", 32'(in_ready), 32'd1);
            end
        join
        @(posedge clk);

        // Reset while a word is held: it must never be transferred.
        #1 out_ready = 1'b0;
        send_m(32'h00000013, 3'b011, 32'h0000006F);
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid   = 1'b1;
        cur_exp    = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        rand_done = 1'b0;
        fork
            begin
                logic [31:0] imm;
                for (int i = 0; i < 40; i++) begin
                    imm = $urandom;
                    if ($urandom_range(0, 1) == 0) imm = {{20{imm[11]}}, imm[11:1], 1'b0};
                    send_m(imm, 3'($urandom_range(0, 7)), $urandom);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        waited = 0;
        while (q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        #1 check("drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
